// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared constants for the modular up/down counter slice.
//   - DEF_WIDTH / DEF_PRESCALE_W : default parameter values
//   - DIR_UP / DIR_DOWN          : encoding of the 'up' input
//   - MODE_WRAP / MODE_SAT       : encoding of the 'sat_mode' input
package counter_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_PRESCALE_W = 8;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage : counter_pkg

// File: rtl/mod_updown_counter_if.sv
// mod_updown_counter_if
//   Control/status bundle of the up/down counter.
//   Controls : en, up, load, load_val, mod_max, sat_mode, presc_div, clr_flag
//   Status   : count, tc, ovf
//   Modports : master drives controls and observes status,
//              slave (the counter) consumes controls and drives status.
interface mod_updown_counter_if
  import counter_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
);

  logic                  en;
  logic                  up;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [WIDTH-1:0]      mod_max;
  logic                  sat_mode;
  logic [PRESCALE_W-1:0] presc_div;
  logic                  clr_flag;
  logic [WIDTH-1:0]      count;
  logic                  tc;
  logic                  ovf;

  modport master (
    output en, up, load, load_val, mod_max, sat_mode, presc_div, clr_flag,
    input  count, tc, ovf
  );

  modport slave (
    input  en, up, load, load_val, mod_max, sat_mode, presc_div, clr_flag,
    output count, tc, ovf
  );

endinterface : mod_updown_counter_if

// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Divides enabled cycles into ticks: one tick every div+1 enabled cycles.
//   Ports:
//     clk   : clock
//     rst_n : synchronous reset, active-high
//     en    : advance enable; prescaler holds while low
//     clr   : restart the prescaler from 0 (no tick allowed upstream)
//     div   : terminal value of the prescaler
//     tick  : combinational, high when enabled and the prescaler is at div
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] p_reg;
  logic [PRESCALE_W-1:0] p_next;

  // Compared with equality, so a div lowered below p_reg lets p run through
  // the full range before matching again.
  assign tick = en && (p_reg == div);

  always_comb begin
    p_next = p_reg;
    if (clr) begin
      p_next = '0;
    end else if (en) begin
      p_next = tick ? '0 : p_reg + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      p_reg <= '0;
    end else begin
      p_reg <= p_next;
    end
  end

endmodule : tick_prescaler

// File: rtl/mod_updown_counter.sv
// mod_updown_counter
//   Up/down counter over 0..mod_max with prescaler, parallel load (clamped
//   to mod_max), wrap/saturate boundary handling, a one-cycle terminal-count
//   pulse and a sticky boundary flag.
//   Ports:
//     clk   : clock
//     rst_n : synchronous reset, active-high (asserted = 1)
//     bus   : slave side of mod_updown_counter_if (controls in, status out)
//   All status outputs come straight from flops.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  mod_updown_counter_if.slave  bus
);

  logic             tick;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             tc_reg, tc_next;
  logic             ovf_reg, ovf_next;
  logic [WIDTH-1:0] load_clamped;
  logic             boundary;

  // Load restarts the prescaler; its tick output is ignored during a load.
  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .clr   (bus.load),
    .div   (bus.presc_div),
    .tick  (tick)
  );

  always_comb begin
    load_clamped = (bus.load_val > bus.mod_max) ? bus.mod_max : bus.load_val;
    boundary     = 1'b0;
    count_next   = count_reg;

    if (bus.load) begin
      count_next = load_clamped;
    end else if (tick) begin
      if (bus.up == DIR_UP) begin
        // >= rather than == so a count stranded above a shrunken mod_max
        // is treated as sitting on the top boundary.
        if (count_reg >= bus.mod_max) begin
          boundary   = 1'b1;
          count_next = (bus.sat_mode == MODE_SAT) ? bus.mod_max : '0;
        end else begin
          count_next = count_reg + WIDTH'(1);
        end
      end else begin
        if (count_reg == '0) begin
          boundary   = 1'b1;
          count_next = (bus.sat_mode == MODE_SAT) ? '0 : bus.mod_max;
        end else if (count_reg > bus.mod_max) begin
          // Re-enter the legal range instead of stepping down from outside it.
          count_next = bus.mod_max;
        end else begin
          count_next = count_reg - WIDTH'(1);
        end
      end
    end

    tc_next  = boundary;
    // A boundary event in the same cycle beats the clear request.
    ovf_next = boundary | (ovf_reg & ~bus.clr_flag);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      count_reg <= '0;
      tc_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign bus.count = count_reg;
  assign bus.tc    = tc_reg;
  assign bus.ovf   = ovf_reg;

endmodule : mod_updown_counter
